dmem_responder: RTL

- Multi-cycle data-memory responder for the pipelined core.
- Serves the MEM stage's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Provides word storage of configurable depth and configurable access latency.
- Replaces the zero-latency data memory when the pipeline is extended to stall on memory.

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the pipelined core's MEM stage.
// Serves one load/store at a time over valid/ready request and response
// channels, with word storage of 2^ADDR_WIDTH words and a fixed LATENCY
// (1..15) from request acceptance to the first cycle of resp_valid.
// After reset the whole array is cleared before any request is accepted.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] clr_q, clr_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Captured request attributes; only meaningful between acceptance and response.
  logic                  wr_q, wr_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  logic [31:0]           mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_mis;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]           rd_word;

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr_hi;

  assign req_idx        = req_addr[ADDR_WIDTH+1:2];
  assign req_mis        = (req_addr[1:0] != 2'b00);
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  // With LATENCY==1 the response word is read at the acceptance edge, so the
  // read port looks at the live request; otherwise at the captured index.
  assign rd_idx  = (state_q == S_IDLE) ? req_idx : idx_q;
  assign rd_word = mem[rd_idx];

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = err_q;

  // Next-state logic: init sweep, acceptance, latency countdown, response hold.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    wcnt_d    = wcnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wr_d      = wr_q;
    mis_d     = mis_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_waddr = clr_q;
    mem_wdata = 32'h0;

    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = 32'h0;
        clr_d     = clr_q + 1'b1;
        if (&clr_q) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (req_valid) begin
          wr_d  = req_write;
          mis_d = req_mis;
          idx_d = req_idx;
          // Stores commit at acceptance so a following load always sees them.
          if (req_write && !req_mis) begin
            mem_we    = 1'b1;
            mem_waddr = req_idx;
            mem_wdata = req_wdata;
          end
          if (LATENCY == 1) begin
            state_d = S_RESP;
            rdata_d = (!req_write && !req_mis) ? rd_word : 32'h0;
            err_d   = req_mis;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = 4'(LATENCY - 1);
          end
        end
      end

      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          state_d = S_RESP;
          rdata_d = (!wr_q && !mis_q) ? rd_word : 32'h0;
          err_d   = mis_q;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_INIT;
        clr_d   = '0;
      end
    endcase
  end

  // Control and response registers; reset aborts any transaction and restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      clr_q   <= '0;
      wcnt_q  <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Captured request attributes need no reset: they are always written before use.
  always_ff @(posedge clk) begin
    wr_q  <= wr_d;
    mis_q <= mis_d;
    idx_q <= idx_d;
  end

  // Single write port shared by the init sweep and accepted stores; suppressed under reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule
